// File: rtl/booth_arb_pkg.sv
// Shared state encoding and round-robin helpers for the Booth multiplier arbiter.
package booth_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_REQ   = 32;
    localparam int MAX_REQ_W = 5;

    function automatic int id_w(input int nreq);
        return (nreq > 2) ? $clog2(nreq) : 1;
    endfunction

    // One-hot grant for the first set bit at or after ptr, wrapping at nreq.
    function automatic logic [MAX_REQ-1:0] rr_next(input logic [MAX_REQ-1:0] valid,
                                                   input int nreq, input int ptr);
        logic [MAX_REQ-1:0]   gnt;
        logic [MAX_REQ_W-1:0] idx;
        gnt = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                idx = MAX_REQ_W'((ptr + k) % nreq);
                if (valid[idx]) begin
                    gnt      = '0;
                    gnt[idx] = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/booth_seq_core.sv
// Iterative radix-2 Booth multiplier: one add/subtract-and-shift step per clock.
module booth_seq_core
    import booth_arb_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                  oClk,
    input  logic                  oRst,
    input  logic                  start,
    input  logic signed [N-1:0]   m,
    input  logic signed [N-1:0]   q,
    output logic                  done,
    output logic signed [2*N-1:0] p
);

    localparam int CNT_W = $clog2(N + 1);

    logic signed [N:0]   a_q, a_d;
    logic [N-1:0]        q_q, q_d;
    logic                qp_q, qp_d;
    logic signed [N-1:0] m_q, m_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic signed [N:0]   m_ext;
    logic signed [N:0]   sum;
    logic signed [N:0]   step_a;
    logic [N-1:0]        step_q;

    always_comb begin
        m_ext = {m_q[N-1], m_q};
        case ({q_q[0], qp_q})
            2'b10:   sum = a_q - m_ext;
            2'b01:   sum = a_q + m_ext;
            default: sum = a_q;
        endcase
        // Arithmetic shift of {A, Q, q_prev}: A's LSB moves into Q's MSB.
        step_a = {sum[N], sum[N:1]};
        step_q = {sum[0], q_q[N-1:1]};

        a_d   = a_q;
        q_d   = q_q;
        qp_d  = qp_q;
        m_d   = m_q;
        cnt_d = cnt_q;
        if (start) begin
            a_d   = '0;
            q_d   = q;
            qp_d  = 1'b0;
            m_d   = m;
            cnt_d = CNT_W'(N);
        end else if (cnt_q != '0) begin
            a_d   = step_a;
            q_d   = step_q;
            qp_d  = q_q[0];
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge oClk or posedge oRst) begin
        if (oRst) begin
            a_q   <= '0;
            q_q   <= '0;
            qp_q  <= 1'b0;
            m_q   <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            q_q   <= q_d;
            qp_q  <= qp_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
        end
    end

    // Product of the step being taken now, so the caller can register it on the last step.
    assign done = (cnt_q == CNT_W'(1));
    assign p    = {step_a[N-1:0], step_q};

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin front end sharing one iterative Booth multiplier among NREQ clients.
module booth_mult_arbiter
    import booth_arb_pkg::*;
#(
    parameter  int N    = 32,
    parameter  int NREQ = 4,
    localparam int ID_W = id_w(NREQ)
) (
    input  logic                  oClk,
    input  logic                  oRst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*N-1:0]     req_m,
    input  logic [NREQ*N-1:0]     req_q,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic signed [2*N-1:0] rsp_p,
    output logic [ID_W-1:0]       rsp_id
);

    state_t                state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic signed [2*N-1:0] rsp_p_q, rsp_p_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;

    logic [MAX_REQ-1:0]    valid_ext;
    logic [MAX_REQ-1:0]    gnt_ext;
    logic                  window;
    logic                  accept;
    logic [ID_W-1:0]       sel;
    logic signed [N-1:0]   m_sel, q_sel;
    logic                  core_done;
    logic signed [2*N-1:0] core_p;

    always_comb begin
        valid_ext            = '0;
        valid_ext[NREQ-1:0]  = req_valid;
        gnt_ext              = rr_next(valid_ext, NREQ, int'(rr_ptr_q));
        window    = !oRst && ((state_q == IDLE) || ((state_q == DONE) && rsp_ready));
        accept    = window && (|gnt_ext);
        req_ready = accept ? gnt_ext[NREQ-1:0] : '0;

        sel   = '0;
        m_sel = '0;
        q_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_ext[i]) begin
                sel   = ID_W'(i);
                m_sel = req_m[i*N +: N];
                q_sel = req_q[i*N +: N];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_p_d     = rsp_p_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            IDLE: ;
            RUN: begin
                if (core_done) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_p_d     = core_p;
                    rsp_id_d    = id_q;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // An accept in DONE shares the cycle with the response handshake.
        if (accept) begin
            state_d  = RUN;
            id_d     = sel;
            rr_ptr_d = (sel == ID_W'(NREQ - 1)) ? '0 : sel + 1'b1;
        end
    end

    always_ff @(posedge oClk or posedge oRst) begin
        if (oRst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_p_q     <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_p_q     <= rsp_p_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    booth_seq_core #(.N(N)) u_core (
        .oClk  (oClk),
        .oRst  (oRst),
        .start (accept),
        .m     (m_sel),
        .q     (q_sel),
        .done  (core_done),
        .p     (core_p)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_p     = rsp_p_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Randomized and directed bench for booth_mult_arbiter against a cycle-timed transaction model.
module tb_booth_mult_arbiter;
    import booth_arb_pkg::*;

    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int ID_W = id_w(NREQ);

    logic                oClk = 1'b0;
    logic                oRst = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*N-1:0]   req_m = '0;
    logic [NREQ*N-1:0]   req_q = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [2*N-1:0]      rsp_p;
    logic [ID_W-1:0]     rsp_id;

    booth_mult_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .oClk      (oClk),
        .oRst      (oRst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_m     (req_m),
        .req_q     (req_q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id)
    );

    always #5 oClk = ~oClk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Transaction model: one outstanding product, visible N+1 cycles after its accept cycle.
    int          cyc     = 0;
    bit          pend    = 1'b0;
    int          due     = 0;
    logic [63:0] exp_p   = '0;
    int          exp_id  = 0;
    int          ptr_m   = 0;
    int          last_g  = -1;
    int          acc_cyc = 0;

    function automatic logic [N-1:0] rnd_op();
        logic [N-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h8000_0000;
            1:       v = 32'h7fff_ffff;
            2:       v = '1;
            3:       v = '0;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic tick(input int refill);
        @(negedge oClk);
        if (last_g >= 0) begin
            req_m[last_g*N +: N] = rnd_op();
            req_q[last_g*N +: N] = rnd_op();
            case (refill)
                2:       req_valid[last_g] = 1'b1;
                1:       req_valid[last_g] = 1'($urandom_range(0, 1));
                default: req_valid[last_g] = 1'b0;
            endcase
        end
    endtask

    task automatic cycle_check();
        logic [NREQ-1:0] exp_rdy;
        bit              vis;
        bit              win;
        int              g;
        int              idx;
        longint          ms;
        longint          qs;
        #1;
        vis = pend && (cyc >= due);
        chk("rsp_valid", rsp_valid, 64'(vis));
        if (vis) begin
            chk("rsp_p", rsp_p, exp_p);
            chk("rsp_id", rsp_id, 64'(exp_id));
        end
        win = !pend || (vis && rsp_ready);
        g = -1;
        if (win) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (ptr_m + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, 64'(exp_rdy));
        if (vis && rsp_ready) pend = 1'b0;
        if (g >= 0) begin
            ms      = longint'($signed(req_m[g*N +: N]));
            qs      = longint'($signed(req_q[g*N +: N]));
            exp_p   = 64'(ms * qs);
            exp_id  = g;
            pend    = 1'b1;
            due     = cyc + N + 1;
            ptr_m   = (g + 1) % NREQ;
            acc_cyc = cyc;
        end
        last_g = g;
        cyc++;
    endtask

    task automatic drain();
        int b;
        b = 0;
        do begin
            tick(0);
            req_valid = '0;
            rsp_ready = 1'b1;
            cycle_check();
            b++;
        end while (pend && b < 4 * N);
    endtask

    task automatic single(input int id, input logic [N-1:0] m, input logic [N-1:0] q,
                          input logic [63:0] lit, input string tag);
        int a;
        int c;
        bit seen;
        drain();
        tick(0);
        req_valid            = '0;
        rsp_ready            = 1'b1;
        req_valid[id]        = 1'b1;
        req_m[id*N +: N]     = m;
        req_q[id*N +: N]     = q;
        cycle_check();
        a = acc_cyc;
        chk({tag, "_grant"}, req_ready, 64'(1) << id);
        seen = 1'b0;
        for (int i = 0; i < N + 8 && !seen; i++) begin
            tick(0);
            c = cyc;
            cycle_check();
            if (rsp_valid) begin
                seen = 1'b1;
                chk({tag, "_latency"}, 64'(c - a), 64'(N + 1));
                chk({tag, "_p"}, rsp_p, lit);
                chk({tag, "_id"}, rsp_id, 64'(id));
            end
        end
        if (!seen) chk({tag, "_timeout"}, 64'(0), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          gq[$];
        int          cq[$];
        int          fair_order[5];
        int          b;
        bit          seen;
        logic [63:0] bp_exp;
        longint      bm;
        longint      bq;

        // Reset state, including grant suppression while reset is held.
        #1 oRst = 1'b1;
        #1;
        chk("rst_rsp_valid", rsp_valid, 64'(0));
        chk("rst_rsp_p", rsp_p, 64'(0));
        chk("rst_rsp_id", rsp_id, 64'(0));
        chk("rst_req_ready_idle", req_ready, 64'(0));
        req_valid = '1;
        #1;
        chk("rst_req_ready_valid", req_ready, 64'(0));
        req_valid = '0;
        @(negedge oClk);
        @(negedge oClk);
        oRst = 1'b0;

        // Directed products; last requester is 3 so the pointer ends at 0.
        single(0, 32'd3,        32'd5,        64'd15,                  "mul_3x5");
        single(1, -32'sd7,      32'd6,        -64'sd42,                "mul_m7x6");
        single(2, -32'sd1,      -32'sd1,      64'd1,                   "mul_m1xm1");
        single(0, 32'h8000_0000, 32'h7fff_ffff, 64'hC000_0000_8000_0000, "mul_minxmax");
        single(3, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mul_minxmin");
        drain();

        // Fairness: all requesters hold valid with fresh operands after each grant.
        fair_order = '{0, 1, 2, 3, 0};
        tick(0);
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]    = 1'b1;
            req_m[i*N +: N] = rnd_op();
            req_q[i*N +: N] = rnd_op();
        end
        rsp_ready = 1'b1;
        cycle_check();
        if (last_g >= 0) begin gq.push_back(last_g); cq.push_back(acc_cyc); end
        b = 0;
        while (gq.size() < 5 && b < 6 * (N + 1)) begin
            tick(2);
            cycle_check();
            if (last_g >= 0) begin gq.push_back(last_g); cq.push_back(acc_cyc); end
            b++;
        end
        chk("fair_count", 64'(gq.size()), 64'(5));
        for (int i = 0; i < gq.size() && i < 5; i++) begin
            chk("fair_order", 64'(gq[i]), 64'(fair_order[i]));
            if (i > 0) chk("fair_interval", 64'(cq[i] - cq[i-1]), 64'(N + 1));
        end
        drain();

        // Backpressure: hold DONE for 10 cycles, then release with requester 2 waiting.
        tick(0);
        req_valid       = '0;
        rsp_ready       = 1'b0;
        req_valid[1]    = 1'b1;
        req_m[1*N +: N] = 32'd12345;
        req_q[1*N +: N] = -32'sd678;
        bm = 12345;
        bq = -678;
        bp_exp = 64'(bm * bq);
        cycle_check();
        seen = 1'b0;
        for (int i = 0; i < N + 8 && !seen; i++) begin
            tick(0);
            cycle_check();
            seen = rsp_valid;
        end
        if (!seen) chk("bp_timeout", 64'(0), 64'(1));
        for (int i = 0; i < 10; i++) begin
            tick(0);
            req_valid[2]    = 1'b1;
            req_m[2*N +: N] = rnd_op();
            req_q[2*N +: N] = rnd_op();
            cycle_check();
            chk("bp_hold_p", rsp_p, bp_exp);
            chk("bp_hold_id", rsp_id, 64'(1));
            chk("bp_hold_ready", req_ready, 64'(0));
        end
        tick(0);
        rsp_ready = 1'b1;
        cycle_check();
        chk("bp_release_grant", req_ready, 64'(4'b0100));
        drain();

        // Reset five cycles into RUN: no response, pointer back to 0.
        tick(0);
        req_valid       = '0;
        req_valid[1]    = 1'b1;
        req_m[1*N +: N] = rnd_op();
        req_q[1*N +: N] = rnd_op();
        cycle_check();
        for (int i = 0; i < 5; i++) begin
            tick(0);
            cycle_check();
        end
        @(negedge oClk);
        req_valid = '1;
        #2 oRst = 1'b1;
        #1;
        chk("midrun_rst_valid", rsp_valid, 64'(0));
        chk("midrun_rst_p", rsp_p, 64'(0));
        chk("midrun_rst_id", rsp_id, 64'(0));
        chk("midrun_rst_ready", req_ready, 64'(0));
        @(negedge oClk);
        chk("midrun_rst_hold_valid", rsp_valid, 64'(0));
        @(negedge oClk);
        oRst   = 1'b0;
        pend   = 1'b0;
        ptr_m  = 0;
        last_g = -1;
        cycle_check();
        chk("post_rst_grant0", req_ready, 64'(4'b0001));
        for (int i = 0; i < N + 4; i++) begin
            tick(0);
            rsp_ready = 1'b1;
            cycle_check();
        end
        drain();

        // Random traffic with random backpressure and occasional withdrawn requests.
        for (int t = 0; t < 2000; t++) begin
            tick(1);
            for (int i = 0; i < NREQ; i++) begin
                if (i != last_g) begin
                    if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                        req_valid[i] = 1'b0;
                    end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                        req_valid[i]    = 1'b1;
                        req_m[i*N +: N] = rnd_op();
                        req_q[i*N +: N] = rnd_op();
                    end
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle_check();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mult_arbiter.md
# booth_mult_arbiter

Shares one iterative radix-2 Booth multiplier core among NREQ requesters. Each requester presents a signed operand pair through a valid/ready handshake. A round-robin arbiter grants one requester, the core runs N Booth steps, and the product comes back on a single response channel tagged with the requester ID. The block sits between the multiply clients and the shared multiplier datapath, in the oClk domain.

## Interface
- N, 32: operand width; product is 2N bits.
- NREQ, 4: number of requesters, at least 2. ID_W = max(1, clog2(NREQ)).
- oClk  in  1  clock; all state changes on its rising edge.
- oRst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester grant; one-hot or zero.
- req_m  in  NREQ*N  multiplicands, signed; requester i occupies bits [i*N +: N].
- req_q  in  NREQ*N  multipliers, signed; same packing.
- rsp_valid  out  1  product valid.
- rsp_ready  in  1  consumer accepts the product.
- rsp_p  out  2N  signed product M*Q.
- rsp_id  out  ID_W  index of the requester that owns rsp_p.

## Operation
- FSM states: IDLE, RUN, DONE.
- Accept window: state==IDLE, or state==DONE with rsp_ready=1. Outside the window req_ready=0.
- Grant: combinational. The first i with req_valid[i]=1, searching from rr_ptr upward with wrap, gets req_ready[i]=1.
- Requesters must not make req_valid depend on req_ready.
- A request whose valid drops before grant is ignored; no state changes.
- Accept, when req_valid[i] and req_ready[i] are both high:
  - latch M_reg=req_m[i], Q_reg=req_q[i], A=0 (N+1 bits, sign-extended arithmetic), q_prev=0, cnt=N, id=i;
  - set rr_ptr=(i+1) mod NREQ;
  - go to RUN.
- RUN, one Booth step per cycle:
  - {Q_reg[0],q_prev}=10: A -= sext(M_reg);
  - {Q_reg[0],q_prev}=01: A += sext(M_reg);
  - then arithmetic right shift of {A,Q_reg,q_prev} by 1;
  - cnt decrements; on the step with cnt==1, go to DONE.
- The accumulator is N+1 bits so that M = -2^(N-1) does not overflow. Final product = {A[N-1:0], Q_reg}; only the low 2N bits are kept.
- DONE: rsp_valid=1, rsp_p and rsp_id held stable until rsp_ready=1.
  - On handshake with a new accept in the same cycle: go to RUN.
  - On handshake with no accept: go to IDLE.
- Reset values: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_p=0, rsp_id=0, req_ready=0, internal registers 0.
- Reset mid-RUN or mid-DONE: the operation is aborted and no response is produced.

## Timing
- Accept at rising edge t. RUN occupies cycles t+1 .. t+N. rsp_valid is high from cycle t+N+1.
- Latency from accept edge to rsp_valid: N+1 cycles.
- Best-case throughput: one product per N+1 cycles, achieved when rsp_ready is held high and the next request is accepted in DONE.
- rsp_valid, rsp_p and rsp_id are registered. req_ready is combinational from req_valid, state and rr_ptr.
- Backpressure: with rsp_ready=0, DONE is held indefinitely and req_ready stays 0.

## Structure
- Package booth_arb_pkg:
  - state_t enum {IDLE, RUN, DONE};
  - rr_next function (round-robin search from the pointer);
  - ID_W helper.
- Sub-module booth_seq_core:
  - ports: start, m, q, done, p;
  - contains A, Q_reg, q_prev, M_reg and cnt, and performs the step above.
- The top level holds the FSM, rr_ptr, grant logic, id register and response registers.

## Test plan
- Single request: req 0, M=3, Q=5 → rsp_valid exactly N+1 cycles after accept, rsp_p=15, rsp_id=0.
- Signs: M=-7, Q=6 → rsp_p=-42. M=-1, Q=-1 → rsp_p=1.
- Extremes: M=Q=-2^31 → rsp_p=0x4000_0000_0000_0000. M=-2^31, Q=2^31-1 → rsp_p=-2^62+2^31.
- Fairness: all four requesters hold valid, rsp_ready=1 → grant order 0,1,2,3,0, back-to-back every N+1 cycles, each rsp_id matching its operands.
- Backpressure: rsp_ready=0 for 10 cycles in DONE → rsp_p and rsp_id stable, req_ready=0. Releasing rsp_ready with requester 2 valid gives accept in that same cycle.
- Reset: assert oRst at RUN cycle 5 → outputs return to reset values immediately and no rsp_valid appears. After release, a new request completes normally with rr_ptr=0.
